// File: rtl/kgp_pkg.sv
// rtl/kgp_pkg.sv - shared opcodes, ALU codes, flag indices and branch-select encoding
package kgp_pkg;

  localparam int DEF_PC_W  = 32;
  localparam int DEF_OFF_W = 16;

  // Bit positions inside the {c,z,s,v} flag register
  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    OP_ALU, OP_SHIFT, OP_LOAD, OP_STORE,
    OP_B, OP_BR, OP_BCOND, OP_CALL, OP_RET
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_PASS
  } alu_op_e;

  // Which redirect source wins this cycle after priority resolution
  typedef enum logic [2:0] {
    SEL_SEQ, SEL_COND, SEL_B, SEL_BR, SEL_CALL, SEL_RET
  } br_sel_e;

endpackage

// File: rtl/pc_branch_unit_ras.sv
// rtl/pc_branch_unit_ras.sv - circular return-address stack, oldest entry overwritten on full push
module return_addr_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] ptr_m1;

  // ptr names the next free slot; when full it also names the oldest entry
  always_comb begin
    ptr_m1 = ptr - 1'b1;
    top    = mem[ptr_m1];
    full   = (count == CNT_W'(DEPTH));
    empty  = (count == '0);
  end

  // Push/pop bookkeeping; a full push overwrites the oldest slot and keeps count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[ptr] <= push_data;
      ptr      <= ptr + 1'b1;
      if (!full) count <= count + 1'b1;
    end else if (pop && !empty) begin
      ptr   <= ptr_m1;
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - PC sequencer: flag register, branch resolve, RAS-backed call/return
module pc_branch_unit
  import kgp_pkg::*;
#(
  parameter int unsigned     PC_W      = DEF_PC_W,
  parameter int unsigned     OFF_W     = DEF_OFF_W,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flag_we,
  input  logic             alu_c,
  input  logic             alu_z,
  input  logic             alu_s,
  input  logic             alu_v,
  input  logic             b,
  input  logic             br,
  input  logic             bz,
  input  logic             bnz,
  input  logic             bcy,
  input  logic             bncy,
  input  logic             bs,
  input  logic             bns,
  input  logic             bv,
  input  logic             bnv,
  input  logic             Call,
  input  logic             Ret,
  input  logic [OFF_W-1:0] offset,
  input  logic [PC_W-1:0]  reg_target,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_plus1,
  output logic             taken,
  output logic             flush,
  output logic [3:0]       flags,
  output logic             ras_err
);

  br_sel_e         sel;
  logic            cond_hit;
  logic            any_cond;
  logic [PC_W-1:0] rel_target;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] ras_top;
  logic            ras_full;
  logic            ras_empty;
  logic            ras_push;
  logic            ras_pop;

  // Resolve the winning strobe and the condition against the pre-update flags
  always_comb begin
    pc_plus1   = pc + 1'b1;
    rel_target = pc_plus1 + {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
    any_cond   = bz | bnz | bcy | bncy | bs | bns | bv | bnv;
    cond_hit   = (bz   &  flags[FLAG_Z]) | (bnz  & ~flags[FLAG_Z])
               | (bcy  &  flags[FLAG_C]) | (bncy & ~flags[FLAG_C])
               | (bs   &  flags[FLAG_S]) | (bns  & ~flags[FLAG_S])
               | (bv   &  flags[FLAG_V]) | (bnv  & ~flags[FLAG_V]);
    sel = SEL_SEQ;
    if (Ret)           sel = SEL_RET;
    else if (Call)     sel = SEL_CALL;
    else if (br)       sel = SEL_BR;
    else if (b)        sel = SEL_B;
    else if (any_cond) sel = SEL_COND;
  end

  // Redirect decision and target; a return with nothing stacked just falls through
  always_comb begin
    taken  = 1'b0;
    target = rel_target;
    unique case (sel)
      SEL_RET:  begin taken = ~ras_empty; target = ras_top; end
      SEL_CALL: taken = 1'b1;
      SEL_BR:   begin taken = 1'b1; target = reg_target; end
      SEL_B:    taken = 1'b1;
      SEL_COND: taken = cond_hit;
      default:  taken = 1'b0;
    endcase
    ras_push = (sel == SEL_CALL) & ~stall;
    ras_pop  = (sel == SEL_RET) & ~ras_empty & ~stall;
  end

  return_addr_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus1),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  // Architectural PC, flag register and one-cycle status pulses; stall freezes state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      flags   <= '0;
      flush   <= 1'b0;
      ras_err <= 1'b0;
    end else begin
      flush   <= taken & ~stall;
      ras_err <= ~stall & (((sel == SEL_CALL) & ras_full) | ((sel == SEL_RET) & ras_empty));
      if (!stall) begin
        pc <= taken ? target : pc_plus1;
        if (flag_we) flags <= {alu_c, alu_z, alu_s, alu_v};
      end
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb/tb_pc_branch_unit.sv - directed bench with a stack-level reference model of the PC sequencer
module tb_pc_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flag_we, alu_c, alu_z, alu_s, alu_v;
  logic        b, br, bz, bnz, bcy, bncy, bs, bns, bv, bnv, Call, Ret;
  logic [15:0] offset;
  logic [31:0] reg_target;
  logic [31:0] pc, pc_plus1;
  logic        taken, flush, ras_err;
  logic [3:0]  flags;

  int checks = 0;
  int failures = 0;

  pc_branch_unit #(.PC_W(32), .OFF_W(16), .RAS_DEPTH(4), .RESET_PC(32'd0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flag_we(flag_we),
    .alu_c(alu_c), .alu_z(alu_z), .alu_s(alu_s), .alu_v(alu_v),
    .b(b), .br(br), .bz(bz), .bnz(bnz), .bcy(bcy), .bncy(bncy), .bs(bs), .bns(bns),
    .bv(bv), .bnv(bnv), .Call(Call), .Ret(Ret), .offset(offset), .reg_target(reg_target),
    .pc(pc), .pc_plus1(pc_plus1), .taken(taken), .flush(flush), .flags(flags), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  // Reference model: stack kept oldest-first in m_stk[0..m_cnt-1]
  logic [31:0]      m_pc;
  logic [3:0]       m_flags;
  logic [3:0][31:0] m_stk;
  int               m_cnt;
  logic             m_flush, m_err;

  function automatic logic exp_taken();
    logic c, z, s, v;
    {c, z, s, v} = m_flags;
    if (Ret) return m_cnt != 0;
    if (Call || br || b) return 1'b1;
    return (bz && z) || (bnz && !z) || (bcy && c) || (bncy && !c)
        || (bs && s) || (bns && !s) || (bv && v) || (bnv && !v);
  endfunction

  function automatic logic [31:0] exp_target();
    logic [31:0] soff;
    soff = 32'($signed(offset));
    if (Ret) return m_stk[m_cnt-1];
    if (!Call && br) return reg_target;
    return m_pc + 32'd1 + soff;
  endfunction

  function automatic logic [3:0][31:0] next_stk();
    logic [3:0][31:0] s;
    s = m_stk;
    if (!stall && !Ret && Call) begin
      if (m_cnt == 4) begin
        for (int i = 0; i < 3; i++) s[i] = s[i+1];
        s[3] = m_pc + 32'd1;
      end else begin
        s[m_cnt] = m_pc + 32'd1;
      end
    end
    return s;
  endfunction

  function automatic int next_cnt();
    if (stall) return m_cnt;
    if (Ret) return (m_cnt > 0) ? m_cnt - 1 : 0;
    if (Call) return (m_cnt < 4) ? m_cnt + 1 : 4;
    return m_cnt;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc    <= 32'd0;
      m_flags <= 4'd0;
      m_stk   <= '0;
      m_cnt   <= 0;
      m_flush <= 1'b0;
      m_err   <= 1'b0;
    end else begin
      m_pc    <= stall ? m_pc : (exp_taken() ? exp_target() : m_pc + 32'd1);
      m_flags <= (!stall && flag_we) ? {alu_c, alu_z, alu_s, alu_v} : m_flags;
      m_stk   <= next_stk();
      m_cnt   <= next_cnt();
      m_flush <= exp_taken() && !stall;
      m_err   <= !stall && ((Ret && m_cnt == 0) || (!Ret && Call && m_cnt == 4));
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    chk("cmp_pc", pc, m_pc);
    chk("cmp_flags", 32'(flags), 32'(m_flags));
    chk("cmp_flush", 32'(flush), 32'(m_flush));
    chk("cmp_ras_err", 32'(ras_err), 32'(m_err));
    chk("cmp_pc_plus1", pc_plus1, m_pc + 32'd1);
    chk("cmp_taken", 32'(taken), 32'(exp_taken()));
  end

  task automatic clr();
    {stall, flag_we, alu_c, alu_z, alu_s, alu_v} = '0;
    {b, br, bz, bnz, bcy, bncy, bs, bns, bv, bnv, Call, Ret} = '0;
    offset = '0;
    reg_target = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    clr();
  endtask

  task automatic br_to(input logic [31:0] t);
    br = 1'b1;
    reg_target = t;
    tick();
    chk("br_pc", pc, t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clr();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // 1: reset state and sequential fetch
    chk("rst_pc", pc, 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("idle_pc", pc, 32'(i));
    end

    // 2: bz taken with backward offset, bnz falls through
    br_to(32'd10);
    chk("br_flush", 32'(flush), 32'd1);
    flag_we = 1'b1; alu_z = 1'b1;
    tick();
    chk("fw_pc", pc, 32'd11);
    chk("fw_flags", 32'(flags), 32'h4);
    bz = 1'b1; offset = -16'sd3;
    tick();
    chk("bz_pc", pc, 32'd9);
    chk("bz_flush", 32'(flush), 32'd1);
    bnz = 1'b1; offset = 16'd7;
    tick();
    chk("bnz_pc", pc, 32'd10);
    chk("bnz_flush", 32'(flush), 32'd0);

    // 3: condition sees the old flags when flag_we coincides with bz
    flag_we = 1'b1;
    tick();
    chk("clr_flags", 32'(flags), 32'd0);
    flag_we = 1'b1; alu_z = 1'b1; bz = 1'b1; offset = 16'd5;
    tick();
    chk("same_cyc_pc", pc, 32'd12);
    bz = 1'b1; offset = 16'd5;
    tick();
    chk("next_bz_pc", pc, 32'd18);

    // 4: call/return, nesting, overflow
    br_to(32'd20);
    Call = 1'b1; offset = 16'd5;
    tick();
    chk("call_pc", pc, 32'd26);
    br_to(32'd30);
    Ret = 1'b1;
    tick();
    chk("ret_pc", pc, 32'd21);
    for (int i = 0; i < 4; i++) begin Call = 1'b1; tick(); end
    chk("nest_pc", pc, 32'd25);
    for (int i = 0; i < 4; i++) begin
      Ret = 1'b1;
      tick();
      chk("unwind_pc", pc, 32'(25 - i));
    end
    for (int i = 0; i < 5; i++) begin
      Call = 1'b1;
      tick();
      chk("ovf_err", 32'(ras_err), (i == 4) ? 32'd1 : 32'd0);
    end
    chk("ovf_pc", pc, 32'd27);
    for (int i = 0; i < 4; i++) begin
      Ret = 1'b1;
      tick();
      chk("ovf_unwind_pc", pc, 32'(27 - i));
    end
    Ret = 1'b1;
    tick();
    chk("lost_oldest_pc", pc, 32'd25);
    chk("lost_oldest_err", 32'(ras_err), 32'd1);

    // 5: return on empty stack, absolute branch
    br_to(32'd7);
    chk("br7_err_clear", 32'(ras_err), 32'd0);
    Ret = 1'b1;
    tick();
    chk("ret_empty_pc", pc, 32'd8);
    chk("ret_empty_err", 32'(ras_err), 32'd1);
    tick();
    chk("err_pulse_end", 32'(ras_err), 32'd0);
    br_to(32'h100);

    // 6: stall, asynchronous reset mid-call, wrap-around
    stall = 1'b1; b = 1'b1; offset = 16'd10;
    #1 chk("stall_taken", 32'(taken), 32'd1);
    tick();
    chk("stall_pc", pc, 32'h100);
    chk("stall_flush", 32'(flush), 32'd0);
    Call = 1'b1;
    tick();
    chk("pre_rst_call_pc", pc, 32'h101);
    Call = 1'b1;
    #2 rst = 1'b1;
    #1 chk("async_rst_pc", pc, 32'd0);
    chk("async_rst_flush", 32'(flush), 32'd0);
    #1 rst = 1'b0;
    clr();
    tick();
    chk("post_rst_pc", pc, 32'd1);
    Ret = 1'b1;
    tick();
    chk("post_rst_ras_empty", 32'(ras_err), 32'd1);
    chk("post_rst_ret_pc", pc, 32'd2);
    br_to(32'hFFFF_FFFF);
    b = 1'b1; offset = 16'd0;
    tick();
    chk("wrap_pc", pc, 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
